// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue sequencer between the EX stage and the multiplier.
// It accepts one multiply op at a time and drives the multiplier request and
// response handshake. It selects the 32-bit result word from the 64-bit
// product and buffers that word until MEM takes it.
// Optional macro MUL_RESULT_BYPASS_EN: the selected product is presented to MEM
// combinationally in the WAIT cycle, which saves one cycle of latency.
module mul_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              mul_clk,
    input  logic              reset,
    input  logic              es_valid,
    input  logic [2:0]        es_mul_op,
    input  logic [XLEN-1:0]   es_src1,
    input  logic [XLEN-1:0]   es_src2,
    output logic              es_ready,
    input  logic              flush,
    output logic [2:0]        mul_op,
    output logic [XLEN-1:0]   mul_x,
    output logic [XLEN-1:0]   mul_y,
    output logic              to_mul_req_valid,
    input  logic              from_mul_req_ready,
    output logic              to_mul_resp_ready,
    input  logic              from_mul_resp_valid,
    input  logic [2*XLEN-1:0] mul_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [XLEN-1:0]   res_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_op_q;
    logic            r_res_valid;
    logic [XLEN-1:0] r_res_data;

    logic            w_issue_slot;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_resp_take;
    logic            w_bypass_hit;
    logic [XLEN-1:0] w_sel_data;

    // MUL.W keeps the low word, and MULH.W/MULH.WU keep the high word.
    // Any op that is not one-hot returns zero.
    function automatic logic [XLEN-1:0] sel_word(input logic [2:0]        op,
                                                 input logic [2*XLEN-1:0] prod);
        logic [XLEN-1:0] word;
        case (op)
            3'b001:         word = prod[XLEN-1:0];
            3'b010, 3'b100: word = prod[2*XLEN-1:XLEN];
            default:        word = '0;
        endcase
        return word;
    endfunction

    // Handshake decode. The sticky response valid only counts while in WAIT.
    always_comb begin
        w_sel_data   = sel_word(r_op_q, mul_result);
        w_resp_take  = (r_state == S_WAIT) && from_mul_resp_valid;
`ifdef MUL_RESULT_BYPASS_EN
        w_bypass_hit = w_resp_take && res_ready;
`else
        w_bypass_hit = 1'b0;
`endif
        w_issue_slot = (r_state == S_IDLE) ||
                       ((r_state == S_HOLD) && res_ready) ||
                       w_bypass_hit;
        w_req_valid  = es_valid && !flush && !reset && w_issue_slot;
        w_req_fire   = w_req_valid && from_mul_req_ready;
    end

    // State register.
    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A flush overrides everything else and returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_fire) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (w_resp_take) begin
                        if (w_bypass_hit) w_state_nxt = w_req_fire ? S_WAIT : S_IDLE;
                        else              w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (res_ready) w_state_nxt = w_req_fire ? S_WAIT : S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Op capture on issue, and result buffering toward MEM.
    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_op_q      <= 3'b000;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            if (w_req_fire) r_op_q <= es_mul_op;
            if (flush) begin
                r_res_valid <= 1'b0;
            end else if (w_resp_take) begin
                r_res_data  <= w_sel_data;
                r_res_valid <= !w_bypass_hit;
            end else if ((r_state == S_HOLD) && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Output drive. Operands pass straight through from EX to the multiplier.
    always_comb begin
        mul_op            = es_mul_op;
        mul_x             = es_src1;
        mul_y             = es_src2;
        to_mul_req_valid  = w_req_valid;
        es_ready          = w_req_fire;
        to_mul_resp_ready = !((r_state == S_HOLD) && !res_ready);
        res_valid         = r_res_valid;
        res_data          = r_res_data;
`ifdef MUL_RESULT_BYPASS_EN
        if (w_resp_take && !flush) begin
            res_valid = 1'b1;
            res_data  = w_sel_data;
        end
`endif
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl in its default (registered-result) build.
// A small behavioural multiplier answers one cycle after each accepted request.
// Its response valid stays high after the first op.
module tb_mul_issue_ctrl;

    logic        mul_clk;
    logic        reset;
    logic        es_valid;
    logic [2:0]  es_mul_op;
    logic [31:0] es_src1;
    logic [31:0] es_src2;
    logic        es_ready;
    logic        flush;
    logic [2:0]  mul_op;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic        to_mul_req_valid;
    logic        from_mul_req_ready;
    logic        to_mul_resp_ready;
    logic        from_mul_resp_valid = 1'b0;
    logic [63:0] mul_result = 64'd0;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    int checks = 0;
    int errors = 0;

    mul_issue_ctrl #(.XLEN(32)) dut (
        .mul_clk             (mul_clk),
        .reset               (reset),
        .es_valid            (es_valid),
        .es_mul_op           (es_mul_op),
        .es_src1             (es_src1),
        .es_src2             (es_src2),
        .es_ready            (es_ready),
        .flush               (flush),
        .mul_op              (mul_op),
        .mul_x               (mul_x),
        .mul_y               (mul_y),
        .to_mul_req_valid    (to_mul_req_valid),
        .from_mul_req_ready  (from_mul_req_ready),
        .to_mul_resp_ready   (to_mul_resp_ready),
        .from_mul_resp_valid (from_mul_resp_valid),
        .mul_result          (mul_result),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_data            (res_data)
    );

    initial begin
        mul_clk = 1'b0;
        forever #5 mul_clk = ~mul_clk;
    end

    // Multiplier model: product one cycle after req fire, sticky resp valid.
    always @(posedge mul_clk) begin
        if (to_mul_req_valid && from_mul_req_ready) begin
            if (mul_op[2])
                mul_result <= {32'd0, mul_x} * {32'd0, mul_y};
            else
                mul_result <= $signed({{32{mul_x[31]}}, mul_x}) *
                              $signed({{32{mul_y[31]}}, mul_y});
            from_mul_resp_valid <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mul_clk);
        #1;
    endtask

    // One op with MEM always ready: accept at N, result visible at N+2, gone at N+3.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        es_valid  = 1'b1;
        es_mul_op = op;
        es_src1   = a;
        es_src2   = b;
        res_ready = 1'b1;
        #1;
        check({tag, "_accept"}, es_ready, 1);
        check({tag, "_mulx"}, mul_x, a);
        tick();
        es_valid = 1'b0;
        #1;
        check({tag, "_n1_valid"}, res_valid, 0);
        tick();
        #1;
        check({tag, "_n2_valid"}, res_valid, 1);
        check({tag, "_n2_data"}, res_data, exp);
        tick();
        #1;
        check({tag, "_n3_valid"}, res_valid, 0);
    endtask

    initial begin
        reset              = 1'b1;
        es_valid           = 1'b1;
        es_mul_op          = 3'b001;
        es_src1            = 32'd1;
        es_src2            = 32'd1;
        flush              = 1'b0;
        from_mul_req_ready = 1'b1;
        res_ready          = 1'b1;

        // Reset state
        tick();
        tick();
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_es_ready", es_ready, 0);
        check("rst_req_valid", to_mul_req_valid, 0);
        reset    = 1'b0;
        es_valid = 1'b0;
        tick();

        // Word selection
        run_op("mulw", 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
        run_op("mulhw", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        run_op("mulhwu", 3'b100, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        run_op("mulhw_min", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

        // Sticky response valid must not create results while idle
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_spurious", res_valid, 0);
        end

        // Illegal ops are accepted and return zero
        run_op("illegal_zero", 3'b000, 32'd3, 32'd5, 32'h0000_0000);
        run_op("illegal_multi", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0000);

        // Backpressure from MEM while a second op waits in EX
        es_valid  = 1'b1;
        es_mul_op = 3'b001;
        es_src1   = 32'd3;
        es_src2   = 32'd5;
        res_ready = 1'b0;
        #1;
        check("bp_accept1", es_ready, 1);
        tick();
        es_mul_op = 3'b100;
        es_src1   = 32'hFFFF_FFFF;
        es_src2   = 32'hFFFF_FFFF;
        #1;
        check("bp_wait_no_issue", es_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_data", res_data, 32'h0000_000F);
            check("bp_hold_es_ready", es_ready, 0);
            check("bp_hold_resp_ready", to_mul_resp_ready, 0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_issue", es_ready, 1);
        check("bp_release_data", res_data, 32'h0000_000F);
        tick();
        es_valid = 1'b0;
        #1;
        check("bp_op2_n1_valid", res_valid, 0);
        tick();
        #1;
        check("bp_op2_n2_valid", res_valid, 1);
        check("bp_op2_n2_data", res_data, 32'hFFFF_FFFE);
        tick();
        #1;
        check("bp_op2_done", res_valid, 0);

        // Flush blocks issue, then flush in WAIT discards the product
        es_valid  = 1'b1;
        es_mul_op = 3'b001;
        es_src1   = 32'd7;
        es_src2   = 32'd9;
        flush     = 1'b1;
        #1;
        check("flush_blocks_issue", es_ready, 0);
        check("flush_blocks_req", to_mul_req_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_op_accept", es_ready, 1);
        tick();
        es_valid = 1'b0;
        flush    = 1'b1;
        #1;
        check("flush_wait_valid", res_valid, 0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_after1_valid", res_valid, 0);
        tick();
        #1;
        check("flush_after2_valid", res_valid, 0);
        run_op("post_flush", 3'b001, 32'd3, 32'd5, 32'h0000_000F);

        // Reset while holding a result
        es_valid  = 1'b1;
        es_mul_op = 3'b010;
        es_src1   = 32'h8000_0000;
        es_src2   = 32'h8000_0000;
        res_ready = 1'b0;
        #1;
        check("rh_accept", es_ready, 1);
        tick();
        es_valid = 1'b0;
        tick();
        #1;
        check("rh_hold_valid", res_valid, 1);
        check("rh_hold_data", res_data, 32'h4000_0000);
        reset    = 1'b1;
        es_valid = 1'b1;
        #1;
        check("rh_rst_es_ready", es_ready, 0);
        check("rh_rst_req_valid", to_mul_req_valid, 0);
        tick();
        #1;
        check("rh_after_valid", res_valid, 0);
        check("rh_after_data", res_data, 0);
        check("rh_after_es_ready", es_ready, 0);
        reset     = 1'b0;
        es_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        run_op("post_reset", 3'b100, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequencer between the EX stage and the Booth/Wallace multiplier.
- Accepts one multiply op at a time from EX and drives the multiplier request/response handshake.
- Captures the 64-bit product and selects the 32-bit word for MUL.W / MULH.W / MULH.WU.
- Buffers that word until the MEM stage takes it; supports pipeline flush.

Parameters:
XLEN, 32, operand/result width (fixed product width 2*XLEN)

Ports:
mul_clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
es_valid  in  1  EX presents a multiply op
es_mul_op  in  3  one-hot: [0] MUL.W, [1] MULH.W, [2] MULH.WU
es_src1  in  XLEN  multiplicand
es_src2  in  XLEN  multiplier
es_ready  out  1  op accepted this cycle when es_valid & es_ready
flush  in  1  cancel all in-flight/buffered work (exception/ertn)
mul_op  out  3  to multiplier
mul_x  out  XLEN  to multiplier
mul_y  out  XLEN  to multiplier
to_mul_req_valid  out  1  request to multiplier
from_mul_req_ready  in  1  multiplier request ready
to_mul_resp_ready  out  1  controller can take a product
from_mul_resp_valid  in  1  multiplier response valid (level-sticky; see Behaviour)
mul_result  in  2*XLEN  product
res_valid  out  1  selected result available to MEM
res_ready  in  1  MEM accepts result
res_data  out  XLEN  selected result

Behaviour:
- Clock and reset:
  - One clock, mul_clk.
  - reset is synchronous, active-high.
  - Reset values: state=IDLE, res_valid=0, res_data=0, es_ready=0 during reset, to_mul_req_valid=0, op_q=0.
- States: IDLE, WAIT, HOLD.
- Multiplier contract:
  - Product is valid exactly in the cycle after req acceptance (req_fire = to_mul_req_valid & from_mul_req_ready).
  - from_mul_resp_valid stays high after the first op, so it is ANDed with state==WAIT, never used alone.
- Issue:
  - to_mul_req_valid = es_valid & ~flush & (state==IDLE | (state==HOLD & res_ready)).
  - es_ready = to_mul_req_valid & from_mul_req_ready.
  - mul_op/mul_x/mul_y are driven combinationally from es_* inputs.
  - to_mul_resp_ready = 1 unless state==HOLD & ~res_ready.
- On req_fire: op_q <= es_mul_op, state -> WAIT.
- WAIT (one cycle):
  - Select: op_q[0] -> mul_result[31:0]; op_q[1] or op_q[2] -> mul_result[63:32].
  - Signedness is handled inside the multiplier.
  - Latch the selection into res_data, res_valid<=1, state -> HOLD.
- HOLD:
  - res_valid held with stable res_data until res_ready.
  - On res_ready with no new issue: state -> IDLE, res_valid<=0.
  - On res_ready with simultaneous req_fire: state -> WAIT, res_valid<=0 next cycle.
- Latency:
  - EX accept at cycle N; res_valid at N+2.
  - Back-to-back throughput is 1 result per 2 cycles.
- Illegal op (zero or multi-hot es_mul_op): accepted; res_data = 0.
- flush (highest priority after reset):
  - In any state: next state IDLE, res_valid<=0, no issue that cycle.
  - In WAIT the product is discarded.
- Reset mid-operation: same as flush; outputs return to reset values next cycle.

Optional Feature:
MUL_RESULT_BYPASS_EN
- Defined:
  - In WAIT, res_valid=1 combinationally with res_data = selected mul_result.
  - If res_ready in that cycle: state -> IDLE (or WAIT if a new req fires); HOLD is skipped.
  - Otherwise latch and enter HOLD as normal.
  - Latency becomes N+1.
- Undefined: registered-only path as above; res_valid never asserts in WAIT.

Test Plan:
- MUL.W, src1=0xFFFFFFFF, src2=0x00000002, res_ready=1 -> res_data=0xFFFFFFFE, res_valid exactly 2 cycles after accept (1 with bypass).
- MULH.W 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF; MULH.WU same operands -> 0x00000001; MULH.W 0x80000000*0x80000000 -> 0x40000000.
- res_ready=0 for 5 cycles after result, es_valid held with a second op:
  - res_data stable, es_ready=0 throughout.
  - On res_ready=1 the second op issues in the same cycle, and its result follows 2 cycles later.
- flush in WAIT cycle -> res_valid stays 0, state IDLE; next op 3*5 MUL.W -> 0x0000000F with no stale data.
- reset asserted in HOLD -> next cycle res_valid=0, res_data=0, es_ready=0 during reset; normal op after deassert yields correct result.
- Two consecutive ops where from_mul_resp_valid stays 1 between them -> no spurious res_valid in IDLE; exactly one result per accepted op.
